// File: rtl/imm_field_packer.sv
// -----------------------------------------------------------------------------
// imm_field_packer
//
// Dual-lane decode-front stage that feeds the sign extender. For each lane it
// extracts op_code = instr[6:2]. It gathers the scattered RISC-V immediate
// bit-fields into the 32-bit raw-immediate layout that the sign extender
// consumes. It also produces the per-lane sign_extender_en and
// sign_extender_type controls.
//
// The packed bundle is registered in a valid/ready stage that has a one-entry
// skid buffer. in_ready is the inverse of the skid-valid register, so it has
// no combinational path from out_ready. flush is synchronous and drops every
// held bundle.
//
// Optional build macro: IMM_FIELD_PACKER_STATS_EN
//   When defined, the stall_cnt and bundle_cnt ports and counters are present.
//   When undefined, both ports are absent and behaviour is otherwise the same.
// -----------------------------------------------------------------------------
module imm_field_packer #(
  parameter int LANES = 2,   // issue width; only 2 is supported
  parameter int CNT_W = 32   // width of the optional statistics counters
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0][31:0] instr_in,
  input  logic [LANES-1:0]       lane_valid_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0][31:0] imm_out,
  output logic [LANES-1:0][4:0]  op_code_out,
  output logic [LANES-1:0]       sign_extender_en,
  output logic [LANES-1:0]       sign_extender_type,
  output logic [LANES-1:0]       lane_valid_out
`ifdef IMM_FIELD_PACKER_STATS_EN
  ,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       bundle_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Major opcodes (instr[6:2]) that carry an immediate
  // ---------------------------------------------------------------------------
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  // funct3 encodings of the OP-IMM shifts; their shamt field is unsigned
  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

  // Per-lane packing result
  typedef struct packed {
    logic [31:0] imm;
    logic        en;
    logic        ty;
  } lane_pack_t;

  // One full bundle as it is held in the main and skid registers
  typedef struct packed {
    logic [LANES-1:0][31:0] imm;
    logic [LANES-1:0][4:0]  op;
    logic [LANES-1:0]       en;
    logic [LANES-1:0]       ty;
    logic [LANES-1:0]       lv;
  } bundle_t;

  // ---------------------------------------------------------------------------
  // Field scatter/gather for one instruction.
  // Most formats are left as raw fields for the extender. STORE, JAL and JALR
  // are already sign-extended here. BRANCH stays zero-extended at 13 bits.
  // ---------------------------------------------------------------------------
  function automatic lane_pack_t pack_lane(input logic [31:0] ins,
                                           input logic        vld);
    lane_pack_t p;
    p = '0;
    if (vld) begin
      case (ins[6:2])
        OP_LUI, OP_AUIPC: begin
          p.imm = {ins[31:12], 12'b0};
          p.en  = 1'b1;
        end
        OP_OPIMM: begin
          p.imm = {20'b0, ins[31:20]};
          p.en  = 1'b1;
          p.ty  = (ins[14:12] == F3_SLLI) || (ins[14:12] == F3_SRLI_SRAI);
        end
        OP_LOAD: begin
          p.imm = {20'b0, ins[31:20]};
          p.en  = 1'b1;
        end
        OP_STORE: begin
          p.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
          p.en  = 1'b1;
        end
        OP_JAL: begin
          p.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
          p.en  = 1'b1;
        end
        OP_JALR: begin
          p.imm = {{20{ins[31]}}, ins[31:20]};
          p.en  = 1'b1;
        end
        OP_BRANCH: begin
          p.imm = {19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
          p.en  = 1'b1;
        end
        default: p = '0;
      endcase
    end
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational packing of the incoming bundle
  // ---------------------------------------------------------------------------
  lane_pack_t             lane_pack [LANES];
  logic [LANES-1:0][31:0] pk_imm;
  logic [LANES-1:0][4:0]  pk_op;
  logic [LANES-1:0]       pk_en;
  logic [LANES-1:0]       pk_ty;
  bundle_t                in_bundle;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    assign lane_pack[n] = pack_lane(instr_in[n], lane_valid_in[n]);
    assign pk_imm[n]    = lane_pack[n].imm;
    assign pk_en[n]     = lane_pack[n].en;
    assign pk_ty[n]     = lane_pack[n].ty;
    // The opcode passes through even for invalid or non-immediate lanes
    assign pk_op[n]     = instr_in[n][6:2];
  end

  assign in_bundle = '{imm: pk_imm, op: pk_op, en: pk_en, ty: pk_ty, lv: lane_valid_in};

  // ---------------------------------------------------------------------------
  // Pipeline state: main register (drives the outputs) plus a one-entry skid
  // ---------------------------------------------------------------------------
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    main_valid_q, main_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    accept;
  logic    main_free;

  // Space is guaranteed whenever the skid is empty, so the handshake needs no
  // knowledge of out_ready. A flush wins over a simultaneous accept.
  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & ~skid_valid_q & ~flush;
  assign main_free = ~main_valid_q | out_ready;

  // Next-state selection for main and skid. The older (skid) bundle always
  // drains into main before any newer bundle, which keeps the order strict.
  always_comb begin
    // NOTE: every output of this block is given a hold value first, so no path leaves it unassigned and no latch is inferred.
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // No accept can happen here because in_ready is low while the skid is full
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_d = in_bundle;
        end
      end
    end else if (accept) begin
      // Main is stalled, so the new bundle parks in the skid register
      skid_d       = in_bundle;
      skid_valid_d = 1'b1;
    end
  end

  // State registers for both pipeline entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload registers are reset too (not only the valids) because the outputs must read zero straight out of reset.
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values regardless of statement order.
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from the main register, so they hold while stalled
  // ---------------------------------------------------------------------------
  assign out_valid          = main_valid_q;
  assign imm_out            = main_q.imm;
  assign op_code_out        = main_q.op;
  assign sign_extender_en   = main_q.en;
  assign sign_extender_type = main_q.ty;
  assign lane_valid_out     = main_q.lv;

`ifdef IMM_FIELD_PACKER_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics. Both counters wrap naturally, and flush leaves them untouched.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bundle_cnt_q;

  // Count stalled output cycles and completed output handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bundle_cnt_q <= '0;
    end else begin
      if (main_valid_q && !out_ready) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (main_valid_q && out_ready) begin
        bundle_cnt_q <= bundle_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bundle_cnt = bundle_cnt_q;
`endif

endmodule

// File: tb/tb_imm_field_packer.sv
// -----------------------------------------------------------------------------
// Testbench for imm_field_packer.
//
// A reference model keeps the held bundles in a queue of at most two entries.
// It builds each expected immediate from the instruction's offset value using
// shift/mask arithmetic. A compare process checks the DUT against the model
// on every falling edge. Directed vectors carry hand-computed literal
// expectations as well. Define IMM_FIELD_PACKER_STATS_EN to also cover the
// statistics counters.
// -----------------------------------------------------------------------------
module tb_imm_field_packer;

  localparam int LANES = 2;
  localparam int CNT_W = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES-1:0][31:0] instr_in;
  logic [LANES-1:0]       lane_valid_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0][31:0] imm_out;
  logic [LANES-1:0][4:0]  op_code_out;
  logic [LANES-1:0]       sign_extender_en;
  logic [LANES-1:0]       sign_extender_type;
  logic [LANES-1:0]       lane_valid_out;
`ifdef IMM_FIELD_PACKER_STATS_EN
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       bundle_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  imm_field_packer #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .instr_in           (instr_in),
    .lane_valid_in      (lane_valid_in),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .imm_out            (imm_out),
    .op_code_out        (op_code_out),
    .sign_extender_en   (sign_extender_en),
    .sign_extender_type (sign_extender_type),
    .lane_valid_out     (lane_valid_out)
`ifdef IMM_FIELD_PACKER_STATS_EN
    ,
    .stall_cnt          (stall_cnt),
    .bundle_cnt         (bundle_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Check helper
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0][31:0] imm;
    logic [1:0][4:0]  op;
    logic [1:0]       en;
    logic [1:0]       ty;
    logic [1:0]       lv;
  } exp_t;

  function automatic logic [31:0] sext(input logic [31:0] x, input int w);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << w;
    return x[w-1] ? (x | m) : x;
  endfunction

  // Expected raw immediate, computed from the instruction's offset value
  function automatic void ref_pack(input logic [31:0] i, input logic v,
                                   output logic [31:0] imm, output logic en, output logic ty);
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [31:0] off;
    op  = 5'(i >> 2);
    f3  = 3'(i >> 12);
    imm = 32'h0;
    en  = 1'b0;
    ty  = 1'b0;
    if (v) begin
      case (op)
        5'b01101, 5'b00101: begin imm = i & 32'hFFFF_F000; en = 1'b1; end
        5'b00100: begin imm = i >> 20; en = 1'b1; ty = (f3 == 3'd1) || (f3 == 3'd5); end
        5'b00000: begin imm = i >> 20; en = 1'b1; end
        5'b01000: begin
          off = ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
          imm = sext(off, 12); en = 1'b1;
        end
        5'b11011: begin
          off = (((i >> 31) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12) |
                (((i >> 20) & 32'h1) << 11) | (((i >> 21) & 32'h3FF) << 1);
          imm = sext(off, 21); en = 1'b1;
        end
        5'b11001: begin imm = sext(i >> 20, 12); en = 1'b1; end
        5'b11000: begin
          off = (((i >> 31) & 32'h1) << 12) | (((i >> 7) & 32'h1) << 11) |
                (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
          imm = off; en = 1'b1;
        end
        default: ;
      endcase
    end
  endfunction

  function automatic exp_t expect_of(input logic [1:0][31:0] ins, input logic [1:0] lv);
    exp_t        e;
    logic [31:0] im;
    logic        en, ty;
    for (int n = 0; n < 2; n++) begin
      ref_pack(ins[n], lv[n], im, en, ty);
      e.imm[n] = im;
      e.en[n]  = en;
      e.ty[n]  = ty;
      e.op[n]  = 5'(ins[n] >> 2);
    end
    e.lv = lv;
    return e;
  endfunction

  exp_t        q[$];
  int unsigned m_stall;
  int unsigned m_bundle;
  bit          m_take;

  // Stage holds up to two bundles; space exists whenever fewer than two are held
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_stall  = 0;
      m_bundle = 0;
    end else begin
      m_take = (q.size() < 2);
      if (q.size() > 0) begin
        if (out_ready) m_bundle++;
        else           m_stall++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && m_take) q.push_back(expect_of(instr_in, lane_valid_in));
      end
    end
  end

  // Compare process on every falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_in_ready",  64'(in_ready),  64'(1));
      check("rst_imm",       64'(imm_out),   64'(0));
      check("rst_en_ty_lv",  64'({sign_extender_en, sign_extender_type, lane_valid_out}), 64'(0));
      check("rst_op",        64'(op_code_out), 64'(0));
    end else begin
      check("cmp_in_ready",  64'(in_ready),  64'(q.size() < 2));
      check("cmp_out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        check("cmp_imm",  64'(imm_out),            64'(q[0].imm));
        check("cmp_op",   64'(op_code_out),        64'(q[0].op));
        check("cmp_en",   64'(sign_extender_en),   64'(q[0].en));
        check("cmp_type", 64'(sign_extender_type), 64'(q[0].ty));
        check("cmp_lv",   64'(lane_valid_out),     64'(q[0].lv));
      end
`ifdef IMM_FIELD_PACKER_STATS_EN
      check("cmp_stall_cnt",  64'(stall_cnt),  64'(m_stall));
      check("cmp_bundle_cnt", 64'(bundle_cnt), 64'(m_bundle));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Drive one cycle of inputs, then return 1 time unit after the next rising edge
  task automatic drive(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] lv, input logic ordy, input logic fl);
    in_valid      = v;
    instr_in[0]   = i0;
    instr_in[1]   = i1;
    lane_valid_in = lv;
    out_ready     = ordy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] INS_A = 32'hAAAA_A0B7;
  localparam logic [31:0] INS_B = 32'hBBBB_B137;
  localparam logic [31:0] INS_C = 32'hCCCC_C1B7;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b0;
    instr_in      = '0;
    lane_valid_in = '0;
    out_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready",  64'(in_ready),  64'(1));
    rst_n = 1'b1;

    // lui + addi -1
    drive(1'b1, 32'h1234_5037, 32'hFFF0_0093, 2'b11, 1'b1, 1'b0);
    check("t1_valid", 64'(out_valid),          64'(1));
    check("t1_imm0",  64'(imm_out[0]),         64'h1234_5000);
    check("t1_imm1",  64'(imm_out[1]),         64'h0000_0FFF);
    check("t1_en",    64'(sign_extender_en),   64'(2'b11));
    check("t1_type",  64'(sign_extender_type), 64'(2'b00));
    check("t1_op",    64'(op_code_out),        64'({5'h04, 5'h0D}));

    // beq -4 on lane 0; lane 1 JAL marked invalid
    drive(1'b1, 32'hFE00_0EE3, 32'h0000_006F, 2'b01, 1'b1, 1'b0);
    check("t2_imm0", 64'(imm_out[0]),        64'h0000_1FFC);
    check("t2_imm1", 64'(imm_out[1]),        64'h0);
    check("t2_en",   64'(sign_extender_en),  64'(2'b01));
    check("t2_lv",   64'(lane_valid_out),    64'(2'b01));
    check("t2_op1",  64'(op_code_out[1]),    64'(5'h1B));

    // sw x13,0(x10) + srai 1
    drive(1'b1, 32'h00D5_2023, 32'h4015_5513, 2'b11, 1'b1, 1'b0);
    check("t3_imm0", 64'(imm_out[0]),         64'h0);
    check("t3_imm1", 64'(imm_out[1]),         64'h0000_0401);
    check("t3_type", 64'(sign_extender_type), 64'(2'b10));

    // jal -1MiB + jalr -4
    drive(1'b1, 32'h8000_00EF, 32'hFFC5_8067, 2'b11, 1'b1, 1'b0);
    check("t4_jal",  64'(imm_out[0]), 64'hFFF0_0000);
    check("t4_jalr", 64'(imm_out[1]), 64'hFFFF_FFFC);

    // sw x1,-4(x2) + lw x1,-2048(x0)
    drive(1'b1, 32'hFE11_2E23, 32'h8000_2083, 2'b11, 1'b1, 1'b0);
    check("t5_store", 64'(imm_out[0]), 64'hFFFF_FFFC);
    check("t5_load",  64'(imm_out[1]), 64'h0000_0800);

    // auipc + custom-0 opcode (no immediate)
    drive(1'b1, 32'h0000_1117, 32'h0000_000B, 2'b11, 1'b1, 1'b0);
    check("t6_auipc", 64'(imm_out[0]),      64'h0000_1000);
    check("t6_en",    64'(sign_extender_en), 64'(2'b01));
    check("t6_op1",   64'(op_code_out[1]),  64'(5'h02));

    // slli 1 on lane 0, JAL on lane 1 with lane 0 marked invalid
    drive(1'b1, 32'h0010_9093, 32'h8000_00EF, 2'b10, 1'b1, 1'b0);
    drive(1'b1, 32'h0010_9093, 32'h8000_00EF, 2'b11, 1'b1, 1'b0);
    check("t7_type", 64'(sign_extender_type), 64'(2'b01));
    check("t7_imm0", 64'(imm_out[0]),         64'h0000_0001);

    drive(1'b0, NOP, NOP, 2'b11, 1'b1, 1'b0);
    check("drain_valid", 64'(out_valid), 64'(0));

    // Back-pressure: A held, B into skid, C refused, then A,B,C in order
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    drive(1'b1, INS_A, NOP, 2'b11, 1'b0, 1'b0);
    check("abc_a_held", 64'(imm_out[0]), 64'hAAAA_A000);
    check("abc_rdy1",   64'(in_ready),   64'(1));
    drive(1'b1, INS_B, NOP, 2'b11, 1'b0, 1'b0);
    check("abc_rdy0",   64'(in_ready),   64'(0));
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, INS_C, NOP, 2'b11, 1'b0, 1'b0);
      check("abc_stall_a", 64'(imm_out[0]), 64'hAAAA_A000);
      check("abc_stall_rdy", 64'(in_ready), 64'(0));
    end
    drive(1'b1, INS_C, NOP, 2'b11, 1'b1, 1'b0);
    check("abc_out_b", 64'(imm_out[0]), 64'hBBBB_B000);
    check("abc_rdy_back", 64'(in_ready), 64'(1));
    drive(1'b1, INS_C, NOP, 2'b11, 1'b1, 1'b0);
    check("abc_out_c", 64'(imm_out[0]), 64'hCCCC_C000);
    drive(1'b0, INS_C, NOP, 2'b11, 1'b1, 1'b0);
    check("abc_empty", 64'(out_valid), 64'(0));
`ifdef IMM_FIELD_PACKER_STATS_EN
    check("stats_stall",  64'(stall_cnt),  64'(5));
    check("stats_bundle", 64'(bundle_cnt), 64'(3));
`endif

    // Flush with skid full and an input presented
    drive(1'b1, INS_A, NOP, 2'b11, 1'b0, 1'b0);
    drive(1'b1, INS_B, NOP, 2'b11, 1'b0, 1'b0);
    drive(1'b1, INS_C, NOP, 2'b11, 1'b0, 1'b1);
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_rdy",   64'(in_ready),  64'(1));
    drive(1'b0, NOP, NOP, 2'b11, 1'b1, 1'b0);
    check("flush_gone",  64'(out_valid), 64'(0));

    // Flush overrides an accept that would otherwise happen
    drive(1'b1, INS_A, NOP, 2'b11, 1'b0, 1'b0);
    drive(1'b1, INS_B, NOP, 2'b11, 1'b1, 1'b1);
    drive(1'b0, NOP, NOP, 2'b11, 1'b1, 1'b0);
    check("flush_accept_gone", 64'(out_valid), 64'(0));

    // Asynchronous reset in the middle of a stall
    drive(1'b1, INS_A, NOP, 2'b11, 1'b0, 1'b0);
    drive(1'b1, INS_B, NOP, 2'b11, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_rdy",   64'(in_ready),  64'(1));
    check("mid_rst_imm",   64'(imm_out),   64'(0));
    check("mid_rst_ctl",   64'({sign_extender_en, sign_extender_type, lane_valid_out, op_code_out}), 64'(0));
`ifdef IMM_FIELD_PACKER_STATS_EN
    check("mid_rst_cnt",   64'({stall_cnt, bundle_cnt}), 64'(0));
`endif
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'h1234_5037, NOP, 2'b11, 1'b1, 1'b0);
    check("post_rst_imm", 64'(imm_out[0]), 64'h1234_5000);
    drive(1'b0, NOP, NOP, 2'b11, 1'b1, 1'b0);
    check("post_rst_empty", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_field_packer.md
Name: imm_field_packer

Overview:
- Dual-lane decode-front stage that feeds the sign extender.
- Takes two raw 32-bit RISC-V instructions per bundle and extracts op_code = instr[6:2].
- Scatters and gathers the immediate bit-fields into the 32-bit "raw immediate" layout the sign extender consumes, and generates the per-lane sign_extender_en / sign_extender_type controls.
- Registered, valid/ready pipeline stage with a one-entry skid buffer and synchronous flush.

Parameters:
- LANES, 2, issue width; only 2 is supported.
- CNT_W, 32, width of the optional statistics counters.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; discards all held bundles.
- in_valid  input  1  bundle present on instr_in.
- in_ready  output  1  stage can accept a bundle this cycle.
- instr_in[1:0]  input  32 each  raw instructions, lane 0 is the older one.
- lane_valid_in  input  2  per-lane instruction valid.
- out_valid  output  1  bundle present on outputs.
- out_ready  input  1  downstream accepts this cycle.
- imm_out[1:0]  output  32 each  packed raw immediate (sign extender "in").
- op_code_out[1:0]  output  5 each  instr[6:2].
- sign_extender_en  output  2  per-lane extender enable.
- sign_extender_type  output  2  per-lane; 1 = unsigned, 0 = signed.
- lane_valid_out  output  2  registered lane_valid_in.
- stall_cnt  output  CNT_W  only with IMM_FIELD_PACKER_STATS_EN.
- bundle_cnt  output  CNT_W  only with IMM_FIELD_PACKER_STATS_EN.

Behaviour:

Packing (combinational, per lane, from instr i = instr_in[n]):
- U (op 01101, 00101): {i[31:12], 12'b0}; en=1, type=0.
- OP-IMM (00100): {20'b0, i[31:20]}; en=1; type=1 when funct3 i[14:12] is 001 or 101 (shifts), else 0.
- LOAD (00000): {20'b0, i[31:20]}; en=1, type=0.
- STORE (01000): {{20{i[31]}}, i[31:25], i[11:7]}, fully sign-extended here; en=1, type=0.
- JAL (11011): {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; en=1, type=0.
- JALR (11001): {{20{i[31]}}, i[31:20]}; en=1, type=0.
- BRANCH (11000): {19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0}; en=1, type=0.
- All other opcodes, or lane_valid_in[n]=0: imm=0, en=0, type=0. op_code_out is still passed through.

Pipeline:
- Main register plus one skid register; each holds the full packed bundle and a valid bit.
- Latency: 1 cycle from accepted input to out_valid.
- Accept condition: in_valid & in_ready.
- in_ready = ~skid_valid, driven from a register with no combinational path from out_ready.
- Main empty, or main full with out_ready=1: the accepted bundle loads main. If skid is full, skid moves to main first; the new bundle goes to skid only when in_ready was high.
- Main full, out_ready=0, bundle accepted: bundle goes to skid; in_ready=0 from next cycle.
- Skid full and out_ready=1: main <= skid; skid_valid <= 0; in_ready=1 next cycle.
- Outputs hold stable while out_valid=1 and out_ready=0. Order is strictly preserved.
- flush=1: both valids clear at the edge, and flush overrides a simultaneous accept. out_valid=0 and in_ready=1 the following cycle.

Reset (asynchronous):
- out_valid=0, in_ready=1, imm_out=0, op_code_out=0, sign_extender_en=0, sign_extender_type=0, lane_valid_out=0, counters=0.
- Reset mid-stall drops both held bundles.

Optional Feature:
- Macro: IMM_FIELD_PACKER_STATS_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 and out_ready=0.
  - bundle_cnt increments on each output handshake (out_valid & out_ready).
  - Both counters wrap at 2^CNT_W to 0 and are not cleared by flush.
- Undefined: the counters and both ports are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then lane0=0x12345037 (lui), lane1=0xFFF00093 (addi -1), out_ready=1 -> next cycle out_valid=1; imm_out[0]=0x12345000, en=11, type=00; imm_out[1]=0x00000FFF.
- Lane0=0xFE000EE3 (beq, imm -4), lane1=0x0000006F with lane_valid_in=01 -> imm_out[0]=0x00001FFC, en=01, imm_out[1]=0.
- Lane0=0x00D52023 (sw x13,0(x10)), lane1=0x40155513 (srai 1) -> imm_out[0]=0x00000000, imm_out[1]=0x00000401, type=10.
- out_ready=0 with 3 back-to-back bundles A, B, C -> A held, B in skid, in_ready=0, C not accepted. Release -> outputs A, B, C in order, one per cycle, nothing lost or duplicated.
- Skid full plus flush asserted together with in_valid -> next cycle out_valid=0, in_ready=1, and the input bundle is discarded.
- STATS_EN build: 5 stall cycles, then 3 handshakes -> stall_cnt=5, bundle_cnt=3. Assert rst_n low mid-stall -> all outputs 0 immediately.
